sequence_packer: RTL
====================

SEQUENCE_PACKER -- requirements
Module: sequence_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, number of packed-word entries buffered between input and output (power of two, 2..16).
REQ-002 clk  in  1  single clock for all logic.
REQ-003 aresetn  in  1  reset, asynchronous assert, active-low.
REQ-004 dac_value_0, dac_value_1  in  16 each, signed  DAC samples; only bits [15:2] are packed.
REQ-005 resync_dac  in  2  per-channel DAC resync flag.
REQ-006 pdm_value_0..pdm_value_3  in  11 each  PDM levels.
REQ-007 enable_dac  in  2; enable_pdm  in  4; enable_dac_ramp_down  in  2  per-channel enable flags.
REQ-008 repeat  in  16  additional output beats for this word (total beats = repeat+1).
REQ-009 in_valid  in  1; in_ready  out  1  input handshake; the word transfers when both are high on a clk edge.
REQ-010 seq_data  out  128  packed sequence word.
REQ-011 seq_valid  out  1; seq_ready  in  1  output handshake; a beat is consumed when both are high.
REQ-012 clear  in  1  synchronous flush of FIFO, repeat counter and underflow state.
REQ-013 underflow  out  1  sticky; underflow_count  out  16  saturating count of underflow cycles.

Function
REQ-014 Bit map SHALL be: [13:0]=dac_value_0[15:2], [14]=resync_dac[0], [29:16]=dac_value_1[15:2], [30]=resync_dac[1], [42:32]=pdm_value_0, [58:48]=pdm_value_1, [74:64]=pdm_value_2, [90:80]=pdm_value_3, [97:96]=enable_dac, [101:98]=enable_pdm, [112]=enable_dac_ramp_down[0], [113]=enable_dac_ramp_down[1]; every other bit is 0.
REQ-015 Packing is truncation, no rounding or saturation; dac_value bits [1:0] are discarded.
REQ-016 Each accepted input writes {packed word, repeat} into the FIFO; in_ready = FIFO not full; in_ready has no combinational path from seq_ready.
REQ-017 Output FSM SHALL have states IDLE (no current word, seq_valid=0) and EMIT (seq_valid=1, seq_data = current word).
REQ-018 IDLE->EMIT on the edge after the FIFO becomes non-empty: pop the entry and load beat counter = repeat. Minimum latency from input accept to seq_valid is 2 cycles.
REQ-019 In EMIT, on each consumed beat: if counter>0, decrement; if counter==0 and FIFO non-empty, pop the next entry in the same edge (gapless); if counter==0 and FIFO empty, go to IDLE.
REQ-020 seq_data SHALL hold the last emitted word in IDLE and must not return to 0 between words.
REQ-021 Underflow: any cycle in IDLE with seq_ready=1 after at least one word has been emitted since reset/clear sets underflow and increments underflow_count, saturating at 65535.
REQ-022 Simultaneous push and pop when full: the pop frees the slot, but in_ready stays 0 that cycle (registered full flag).
REQ-023 clear has priority over push and pop: empties the FIFO, forces IDLE, zeroes seq_data, underflow and underflow_count, and suppresses the input transfer in that cycle.
REQ-024 seq_valid SHALL not drop in EMIT without a consumed final beat (AXI-stream stability); seq_data is stable while seq_valid=1 and seq_ready=0.

Reset
REQ-025 On aresetn low, asynchronously: FIFO empty, FSM IDLE, seq_data=0, seq_valid=0, in_ready=0, counter=0, underflow=0, underflow_count=0.
REQ-026 in_ready goes to 1 on the first clk edge after aresetn deasserts.
REQ-027 Reset during EMIT abandons the current word and remaining repeats without emitting further beats.

Structure
REQ-028 The bit-field offsets and widths of REQ-014 belong in a shared package also used by the sequence decoder, so that encoding and decoding derive from one definition.
REQ-029 One sub-module, seq_fifo (synchronous FIFO, width 144, depth FIFO_DEPTH, full/empty flags), is natural; the packing logic and FSM stay in the top level.

Verification
REQ-030 dac_value_0=16'h7FFC, dac_value_1=16'h8000, resync=2'b11, all else 0, repeat=0 -> one beat with seq_data[13:0]=14'h1FFF, [29:16]=14'h2000, bits 14 and 30 set, all other bits 0.
REQ-031 Word A with repeat=3 then word B with repeat=0, seq_ready=1 continuously -> exactly A,A,A,A,B on consecutive cycles, seq_valid then drops and seq_data stays B.
REQ-032 seq_ready=0 while pushing 3 words, FIFO_DEPTH=2 -> in_ready drops after the input accepts; no word is lost and order is preserved on release.
REQ-033 After one word is emitted, FIFO empty, seq_ready=1 for 5 cycles -> underflow=1, underflow_count=5; clear -> both 0, seq_data=0.
REQ-034 Word with repeat=100 mid-emission, assert aresetn low -> seq_valid=0 and seq_data=0 immediately (without a clk edge); after release, the next input emits with 2-cycle latency.
REQ-035 Round-trip: random fields through the packer and the sequence decoder -> decoded fields equal the inputs, with dac values equal to input & 16'hFFFC.

Source files
------------

// File: rtl/sequence_packer_pkg.sv
// Shared sequence-word layout for the packer and the sequence decoder.
// Holds the bit-field offsets and widths of the 128-bit sequence word,
// the FIFO entry geometry, the output FSM state type and the pack/unpack
// helpers, so encoder and decoder derive from one definition.
package sequence_packer_pkg;

   localparam int unsigned SEQ_W   = 128;
   localparam int unsigned REP_W   = 16;
   localparam int unsigned ENTRY_W = SEQ_W + REP_W;

   localparam int unsigned DAC_W = 14;
   localparam int unsigned PDM_W = 11;

   localparam int unsigned DAC0_LSB    = 0;
   localparam int unsigned RESYNC0_BIT = 14;
   localparam int unsigned DAC1_LSB    = 16;
   localparam int unsigned RESYNC1_BIT = 30;
   localparam int unsigned PDM0_LSB    = 32;
   localparam int unsigned PDM1_LSB    = 48;
   localparam int unsigned PDM2_LSB    = 64;
   localparam int unsigned PDM3_LSB    = 80;
   localparam int unsigned EN_DAC_LSB  = 96;
   localparam int unsigned EN_PDM_LSB  = 98;
   localparam int unsigned EN_RAMP_LSB = 112;

   typedef enum logic [0:0] {
      StIdle,
      StEmit
   } emit_state_e;

   // Unpacked view of one sequence word; dac fields carry full 16-bit samples.
   typedef struct packed {
      logic [15:0]      dac_0;
      logic [15:0]      dac_1;
      logic [1:0]       resync;
      logic [PDM_W-1:0] pdm_0;
      logic [PDM_W-1:0] pdm_1;
      logic [PDM_W-1:0] pdm_2;
      logic [PDM_W-1:0] pdm_3;
      logic [1:0]       en_dac;
      logic [3:0]       en_pdm;
      logic [1:0]       en_ramp;
   } seq_fields_t;

   // DAC samples are truncated: the two LSBs are dropped, no rounding.
   function automatic logic [SEQ_W-1:0] pack_word(input seq_fields_t f);
      logic [SEQ_W-1:0] w;
      w = '0;
      w[DAC0_LSB +: DAC_W]  = f.dac_0[15:2];
      w[RESYNC0_BIT]        = f.resync[0];
      w[DAC1_LSB +: DAC_W]  = f.dac_1[15:2];
      w[RESYNC1_BIT]        = f.resync[1];
      w[PDM0_LSB +: PDM_W]  = f.pdm_0;
      w[PDM1_LSB +: PDM_W]  = f.pdm_1;
      w[PDM2_LSB +: PDM_W]  = f.pdm_2;
      w[PDM3_LSB +: PDM_W]  = f.pdm_3;
      w[EN_DAC_LSB +: 2]    = f.en_dac;
      w[EN_PDM_LSB +: 4]    = f.en_pdm;
      w[EN_RAMP_LSB +: 2]   = f.en_ramp;
      return w;
   endfunction

   function automatic seq_fields_t unpack_word(input logic [SEQ_W-1:0] w);
      seq_fields_t f;
      f         = '0;
      f.dac_0   = {w[DAC0_LSB +: DAC_W], 2'b00};
      f.dac_1   = {w[DAC1_LSB +: DAC_W], 2'b00};
      f.resync  = {w[RESYNC1_BIT], w[RESYNC0_BIT]};
      f.pdm_0   = w[PDM0_LSB +: PDM_W];
      f.pdm_1   = w[PDM1_LSB +: PDM_W];
      f.pdm_2   = w[PDM2_LSB +: PDM_W];
      f.pdm_3   = w[PDM3_LSB +: PDM_W];
      f.en_dac  = w[EN_DAC_LSB +: 2];
      f.en_pdm  = w[EN_PDM_LSB +: 4];
      f.en_ramp = w[EN_RAMP_LSB +: 2];
      return f;
   endfunction

endpackage

// File: rtl/seq_fifo.sv
// Synchronous FIFO for {packed word, repeat} entries.
// Ports: clk, aresetn (async active-low), clear (sync flush), push/wdata,
// pop/rdata (first-word fall-through read of the head entry), full, empty.
// full is registered so it has no combinational path from pop; it reads 1
// while in reset so no push can be accepted before the first clock edge.
module seq_fifo #(
   parameter int unsigned WIDTH = 144,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q, count_d;
   logic             full_q;
   logic             push_ok, pop_ok;

   assign push_ok = push & ~full_q;
   assign pop_ok  = pop & (count_q != '0);

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + (PTR_W+1)'(1);
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b1;
      end else if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
         full_q  <= (count_d == (PTR_W+1)'(DEPTH));
      end
   end

   // Storage needs no reset; validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push_ok && !clear) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = full_q;
   assign empty = (count_q == '0);

endmodule

// File: rtl/sequence_packer.sv
// Packs DAC/PDM channel settings into 128-bit sequence words, buffers them
// with their repeat count, and replays each word repeat+1 times on an
// AXI-stream style output.
// Ports: clk, aresetn (async active-low); channel inputs dac_value_*,
// resync_dac, pdm_value_*, enable_*; repeat_count; in_valid/in_ready input
// handshake; seq_data/seq_valid/seq_ready output handshake; clear (sync
// flush); underflow (sticky) and underflow_count (saturating).
module sequence_packer
   import sequence_packer_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               aresetn,
   input  logic signed [15:0] dac_value_0,
   input  logic signed [15:0] dac_value_1,
   input  logic [1:0]         resync_dac,
   input  logic [10:0]        pdm_value_0,
   input  logic [10:0]        pdm_value_1,
   input  logic [10:0]        pdm_value_2,
   input  logic [10:0]        pdm_value_3,
   input  logic [1:0]         enable_dac,
   input  logic [3:0]         enable_pdm,
   input  logic [1:0]         enable_dac_ramp_down,
   input  logic [15:0]        repeat_count,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [127:0]       seq_data,
   output logic               seq_valid,
   input  logic               seq_ready,
   input  logic               clear,
   output logic               underflow,
   output logic [15:0]        underflow_count
);

   seq_fields_t      fields;
   logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
   logic             fifo_full, fifo_empty;
   logic             push, pop;
   logic [SEQ_W-1:0] head_word;
   logic [REP_W-1:0] head_rep;

   emit_state_e      state_q;
   logic [SEQ_W-1:0] seq_data_q;
   logic             seq_valid_q;
   logic [REP_W-1:0] beat_cnt_q;
   logic             emitted_q;
   logic             underflow_q;
   logic [15:0]      underflow_count_q;

   always_comb begin
      fields         = '0;
      fields.dac_0   = dac_value_0;
      fields.dac_1   = dac_value_1;
      fields.resync  = resync_dac;
      fields.pdm_0   = pdm_value_0;
      fields.pdm_1   = pdm_value_1;
      fields.pdm_2   = pdm_value_2;
      fields.pdm_3   = pdm_value_3;
      fields.en_dac  = enable_dac;
      fields.en_pdm  = enable_pdm;
      fields.en_ramp = enable_dac_ramp_down;
   end

   assign fifo_wdata = {pack_word(fields), repeat_count};
   assign head_word  = fifo_rdata[ENTRY_W-1:REP_W];
   assign head_rep   = fifo_rdata[REP_W-1:0];

   assign in_ready = ~fifo_full;
   assign push     = in_valid & ~fifo_full & ~clear;
   // Pop when idle with data waiting, or gaplessly on the last beat of a word.
   assign pop = ~clear & ~fifo_empty &
                ((state_q == StIdle) ||
                 (seq_ready && (beat_cnt_q == '0)));

   seq_fifo #(
      .WIDTH(ENTRY_W),
      .DEPTH(FIFO_DEPTH)
   ) u_seq_fifo (
      .clk    (clk),
      .aresetn(aresetn),
      .clear  (clear),
      .push   (push),
      .wdata  (fifo_wdata),
      .pop    (pop),
      .rdata  (fifo_rdata),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q           <= StIdle;
         seq_data_q        <= '0;
         seq_valid_q       <= 1'b0;
         beat_cnt_q        <= '0;
         emitted_q         <= 1'b0;
         underflow_q       <= 1'b0;
         underflow_count_q <= '0;
      end else if (clear) begin
         state_q           <= StIdle;
         seq_data_q        <= '0;
         seq_valid_q       <= 1'b0;
         beat_cnt_q        <= '0;
         emitted_q         <= 1'b0;
         underflow_q       <= 1'b0;
         underflow_count_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               // Consumer ready but nothing to give, once the stream has started.
               if (emitted_q && seq_ready) begin
                  underflow_q <= 1'b1;
                  if (underflow_count_q != 16'hFFFF) begin
                     underflow_count_q <= underflow_count_q + 16'd1;
                  end
               end
               if (!fifo_empty) begin
                  state_q     <= StEmit;
                  seq_valid_q <= 1'b1;
                  seq_data_q  <= head_word;
                  beat_cnt_q  <= head_rep;
               end
            end
            StEmit: begin
               if (seq_ready) begin
                  emitted_q <= 1'b1;
                  if (beat_cnt_q != '0) begin
                     beat_cnt_q <= beat_cnt_q - 16'd1;
                  end else if (!fifo_empty) begin
                     seq_data_q <= head_word;
                     beat_cnt_q <= head_rep;
                  end else begin
                     // seq_data keeps the last word while idle.
                     state_q     <= StIdle;
                     seq_valid_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q     <= StIdle;
               seq_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign seq_data        = seq_data_q;
   assign seq_valid       = seq_valid_q;
   assign underflow       = underflow_q;
   assign underflow_count = underflow_count_q;

endmodule
